bcd_seq_ctrl: RTL

BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

---
 rtl/bcd_seq_ctrl_pkg.sv | 18 +
 rtl/bcd_seq_ctrl_if.sv | 28 ++
 rtl/bcd_seq_ctrl_bcd2_cnt.sv | 32 +++
 rtl/bcd_seq_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/bcd_seq_ctrl_pkg.sv
// rtl/bcd_seq_ctrl_pkg.sv - shared state encoding and BCD digit constants
package bcd_seq_ctrl_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
        return d <= DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_seq_ctrl_if.sv
// rtl/bcd_seq_ctrl_if.sv - command inputs and count/status outputs of the sequencer
interface bcd_seq_ctrl_if
    import bcd_seq_ctrl_pkg::*;
;
    logic               Start;
    logic               Pause;
    logic               Clr;
    logic               Repeat;
    logic [DIGIT_W-1:0] LimH;
    logic [DIGIT_W-1:0] LimL;
    logic [DIGIT_W-1:0] QH;
    logic [DIGIT_W-1:0] QL;
    logic               Busy;
    logic               Done;
    logic               C;
    logic               Err;

    modport master (
        output Start, Pause, Clr, Repeat, LimH, LimL,
        input  QH, QL, Busy, Done, C, Err
    );

    modport slave (
        input  Start, Pause, Clr, Repeat, LimH, LimL,
        output QH, QL, Busy, Done, C, Err
    );

endinterface

// File: rtl/bcd_seq_ctrl_bcd2_cnt.sv
// rtl/bcd_seq_ctrl_bcd2_cnt.sv - two-digit BCD counter, 00..99, clear has priority over inc
module bcd2_cnt
    import bcd_seq_ctrl_pkg::*;
(
    input  logic               Clk,
    input  logic               MR,
    input  logic               clear,
    input  logic               inc,
    output logic [DIGIT_W-1:0] QH,
    output logic [DIGIT_W-1:0] QL
);

    localparam logic [DIGIT_W-1:0] ONE = 1;

    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            QH <= '0;
            QL <= '0;
        end else if (clear) begin
            QH <= '0;
            QL <= '0;
        end else if (inc) begin
            if (QL == DIGIT_MAX) begin
                QL <= '0;
                QH <= (QH == DIGIT_MAX) ? '0 : QH + ONE;
            end else begin
                QL <= QL + ONE;
            end
        end
    end

endmodule

// File: rtl/bcd_seq_ctrl.sv
// rtl/bcd_seq_ctrl.sv - BCD count sequencer: FSM, limit latch, terminal compare, pulses
module bcd_seq_ctrl
    import bcd_seq_ctrl_pkg::*;
(
    input  logic          Clk,
    input  logic          MR,
    bcd_seq_ctrl_if.slave bus
);

    state_t             state;
    logic [DIGIT_W-1:0] lim_h;
    logic [DIGIT_W-1:0] lim_l;
    logic               rep;
    logic [DIGIT_W-1:0] qh;
    logic [DIGIT_W-1:0] ql;
    logic               busy;
    logic               done;
    logic               wrap;
    logic               err;

    logic can_start;
    logic lim_valid;
    logic start_ok;
    logic start_bad;
    logic at_lim;
    logic run_go;
    logic cnt_clear;
    logic cnt_inc;

    assign can_start = (state == IDLE) || (state == DONE);
    assign lim_valid = digit_ok(bus.LimH) && digit_ok(bus.LimL);
    assign start_ok  = !bus.Clr && bus.Start && can_start && lim_valid;
    assign start_bad = !bus.Clr && bus.Start && can_start && !lim_valid;
    assign at_lim    = (qh == lim_h) && (ql == lim_l);
    // Pause outranks the terminal action, so a held run never wraps or finishes
    assign run_go    = !bus.Clr && (state == RUN) && !bus.Pause;
    assign cnt_clear = bus.Clr || start_ok || (run_go && at_lim && rep);
    assign cnt_inc   = run_go && !at_lim;

    bcd2_cnt u_cnt (
        .Clk   (Clk),
        .MR    (MR),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .QH    (qh),
        .QL    (ql)
    );

    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            state <= IDLE;
            lim_h <= '0;
            lim_l <= '0;
            rep   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            if (bus.Clr) begin
                state <= IDLE;
                busy  <= 1'b0;
                err   <= 1'b0;
            end else if (start_ok) begin
                state <= RUN;
                busy  <= 1'b1;
                lim_h <= bus.LimH;
                lim_l <= bus.LimL;
                rep   <= bus.Repeat;
            end else if (start_bad) begin
                err <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (bus.Pause) begin
                            state <= PAUSE;
                        end else if (at_lim) begin
                            if (rep) begin
                                wrap <= 1'b1;
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (!bus.Pause) state <= RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.QH   = qh;
    assign bus.QL   = ql;
    assign bus.Busy = busy;
    assign bus.Done = done;
    assign bus.C    = wrap;
    assign bus.Err  = err;

endmodule
